// File: rtl/fft_agu_multimode.sv
// Radix-2 in-place FFT address generator: run-time N, DIT/DIF ordering,
// LANES butterflies per beat, valid/ready toward the core, MAX_N-domain twiddles.
module fft_agu_multimode #(
  parameter int MAX_LOG2N = 5,
  parameter int LANES     = 1,
  localparam int W  = MAX_LOG2N,
  localparam int SW = $clog2(MAX_LOG2N),
  localparam int CW = $clog2(MAX_LOG2N + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CW-1:0]          log2n_cfg,
  input  logic                   mode,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [LANES*W-1:0]     idx_a,
  output logic [LANES*W-1:0]     idx_b,
  output logic [LANES*(W-1)-1:0] tw_k,
  output logic [SW-1:0]          stage,
  output logic                   last_in_stage,
  output logic                   done_stage,
  output logic                   done_fft,
  output logic                   busy,
  output logic                   cfg_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [CW-1:0] r_l;
  logic          r_mode;
  logic [W-1:0]  r_base;
  logic [SW-1:0] r_stage;
  logic          r_done_stage;
  logic          r_done_fft;
  logic          r_cfg_err;

  logic          w_run;
  logic          w_cfg_ok;
  logic          w_xfer;
  logic          w_stage_end;
  logic          w_last_stage;
  logic [W:0]    w_cfg_half;
  logic [W-1:0]  w_half_n;
  logic [W-1:0]  w_base_next;
  logic [CW-1:0] w_h;
  logic [W-1:0]  w_half;

  assign w_run = (r_state == S_RUN);

  // The L range check guards the shift, so an out-of-range L never reaches the LANES test.
  assign w_cfg_half = (W+1)'(1) << (log2n_cfg - CW'(1));
  assign w_cfg_ok   = (log2n_cfg != '0) && (log2n_cfg <= CW'(MAX_LOG2N))
                   && (w_cfg_half >= (W+1)'(LANES));

  assign w_half_n     = W'(1) << (r_l - CW'(1));
  assign w_base_next  = r_base + W'(LANES);
  assign w_stage_end  = (w_base_next == w_half_n);
  assign w_last_stage = (CW'(r_stage) == (r_l - CW'(1)));
  assign w_xfer       = w_run && out_ready;

  assign w_h    = r_mode ? (r_l - CW'(1) - CW'(r_stage)) : CW'(r_stage);
  assign w_half = W'(1) << w_h;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_l          <= '0;
      r_mode       <= 1'b0;
      r_base       <= '0;
      r_stage      <= '0;
      r_done_stage <= 1'b0;
      r_done_fft   <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_done_stage <= 1'b0;
      r_done_fft   <= 1'b0;
      r_cfg_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_state <= S_RUN;
              r_l     <= log2n_cfg;
              r_mode  <= mode;
              r_base  <= '0;
              r_stage <= '0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          if (w_xfer) begin
            if (w_stage_end) begin
              r_base       <= '0;
              r_done_stage <= 1'b1;
              if (w_last_stage) begin
                r_done_fft <= 1'b1;
                r_stage    <= '0;
                r_state    <= S_IDLE;
              end else begin
                r_stage <= r_stage + SW'(1);
              end
            end else begin
              r_base <= w_base_next;
            end
          end
        end
      endcase
    end
  end

  assign out_valid     = w_run;
  assign busy          = w_run;
  assign stage         = w_run ? r_stage : '0;
  assign last_in_stage = w_run && w_stage_end;
  assign done_stage    = r_done_stage;
  assign done_fft      = r_done_fft;
  assign cfg_err       = r_cfg_err;

  // Each lane splits j into group g and offset p around the butterfly span 2*half.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [W-1:0]   w_j;
      logic [W-1:0]   w_p;
      logic [W-1:0]   w_g;
      logic [W-1:0]   w_a;
      logic [W-2:0]   w_k;

      assign w_j = r_base + W'(gi);
      assign w_p = w_j & (w_half - W'(1));
      assign w_g = w_j >> w_h;
      assign w_a = (w_g << (w_h + CW'(1))) | w_p;
      assign w_k = (W-1)'(w_p << (CW'(MAX_LOG2N - 1) - w_h));

      assign idx_a[gi*W +: W]         = w_run ? w_a : '0;
      assign idx_b[gi*W +: W]         = w_run ? (w_a + w_half) : '0;
      assign tw_k[gi*(W-1) +: (W-1)]  = w_run ? w_k : '0;
    end
  endgenerate

endmodule

// File: tb/tb_fft_agu_multimode.sv
// Bench for fft_agu_multimode: table-driven transforms scored beat by beat,
// plus stall, reset, multi-lane and config-error sequences.
module tb_fft_agu_multimode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [2:0] log2n_cfg;
  logic       mode;
  logic       out_ready;
  logic       start1, start2, start4;

  logic       ov1, last1, ds1, df1, busy1, err1;
  logic [4:0] a1, b1;
  logic [3:0] k1;
  logic [2:0] st1;

  logic       ov2, last2, ds2, df2, busy2, err2;
  logic [9:0] a2, b2;
  logic [7:0] k2;
  logic [2:0] st2;

  logic        ov4, last4, ds4, df4, busy4, err4;
  logic [19:0] a4, b4;
  logic [15:0] k4;
  logic [2:0]  st4;

  fft_agu_multimode #(.MAX_LOG2N(5), .LANES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .log2n_cfg(log2n_cfg), .mode(mode),
    .out_ready(out_ready), .out_valid(ov1), .idx_a(a1), .idx_b(b1), .tw_k(k1),
    .stage(st1), .last_in_stage(last1), .done_stage(ds1), .done_fft(df1),
    .busy(busy1), .cfg_err(err1));

  fft_agu_multimode #(.MAX_LOG2N(5), .LANES(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .log2n_cfg(log2n_cfg), .mode(mode),
    .out_ready(out_ready), .out_valid(ov2), .idx_a(a2), .idx_b(b2), .tw_k(k2),
    .stage(st2), .last_in_stage(last2), .done_stage(ds2), .done_fft(df2),
    .busy(busy2), .cfg_err(err2));

  fft_agu_multimode #(.MAX_LOG2N(5), .LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .log2n_cfg(log2n_cfg), .mode(mode),
    .out_ready(out_ready), .out_valid(ov4), .idx_a(a4), .idx_b(b4), .tw_k(k4),
    .stage(st4), .last_in_stage(last4), .done_stage(ds4), .done_fft(df4),
    .busy(busy4), .cfg_err(err4));

  typedef struct { logic [4:0] a; logic [4:0] b; logic [3:0] k; } abk_t;
  typedef struct { logic [4:0] a; logic [4:0] b; logic [3:0] k; logic [2:0] stg; logic last; } exp_t;
  typedef struct { int l; logic md; int off; string name; } run_t;

  abk_t tbl[33];
  run_t runs[5];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nb2 = 0;
  logic [9:0] cap_a2[32];
  logic [9:0] cap_b2[32];
  logic [7:0] cap_k2[32];

  function automatic abk_t mk(int a, int b, int k);
    abk_t r;
    r.a = 5'(a);
    r.b = 5'(b);
    r.k = 4'(k);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard side: every LANES=1 transfer pops the next expected beat.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ov1 === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected: got a=%0d b=%0d k=%0d stage=%0d, expected no beat",
                 a1, b1, k1, st1);
      end else begin
        e = exp_q.pop_front();
        if ({a1, b1, k1, st1, last1} !== {e.a, e.b, e.k, e.stg, e.last}) begin
          n_bad++;
          $display("FAIL beat: got a=%0d b=%0d k=%0d stage=%0d last=%0d, expected a=%0d b=%0d k=%0d stage=%0d last=%0d",
                   a1, b1, k1, st1, last1, e.a, e.b, e.k, e.stg, e.last);
        end else begin
          $display("beat stage=%0d a=%0d b=%0d k=%0d last=%0d ok", st1, a1, b1, k1, last1);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (ov2 === 1'b1 && out_ready === 1'b1) begin
      if (nb2 < 32) begin
        cap_a2[nb2] = a2;
        cap_b2[nb2] = b2;
        cap_k2[nb2] = k2;
      end
      $display("lanes2 beat %0d stage=%0d a=%h b=%h k=%h", nb2, st2, a2, b2, k2);
      nb2++;
    end
  end

  task automatic push_run(int r, int count);
    exp_t e;
    int bps;
    bps = 1 << (runs[r].l - 1);
    for (int i = 0; i < count; i++) begin
      e.a    = tbl[runs[r].off + i].a;
      e.b    = tbl[runs[r].off + i].b;
      e.k    = tbl[runs[r].off + i].k;
      e.stg  = 3'(i / bps);
      e.last = ((i % bps) == bps - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(int sel, int l, logic md);
    log2n_cfg = 3'(l);
    mode      = md;
    case (sel)
      1:       start1 = 1'b1;
      2:       start2 = 1'b1;
      default: start4 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  // n0 = negedges already seen since the accepting edge.
  task automatic wait_done(int sel, int n0, int exp_cyc, int exp_stg, string name);
    int   n;
    int   ds;
    logic seen;
    logic v, d, s, b;
    n = n0; ds = 0; seen = 1'b0;
    while (!seen && n < n0 + 300) begin
      @(negedge clk);
      n++;
      case (sel)
        1:       begin v = ov1; d = df1; s = ds1; b = busy1; end
        2:       begin v = ov2; d = df2; s = ds2; b = busy2; end
        default: begin v = ov4; d = df4; s = ds4; b = busy4; end
      endcase
      if (s === 1'b1) ds++;
      if (d === 1'b1) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      check({name, "_done_latency"}, n, exp_cyc);
      check({name, "_done_stage_count"}, ds, exp_stg);
      check({name, "_idle_after"}, {v, b}, 0);
    end
    if (sel == 1) check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic cfg_err_check(int sel, int l, string name);
    log2n_cfg = 3'(l);
    case (sel)
      1:       start1 = 1'b1;
      default: start4 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
    @(negedge clk);
    if (sel == 1) check({name, "_err_busy"}, {err1, busy1}, 2'b10);
    else          check({name, "_err_busy"}, {err4, busy4}, 2'b10);
    @(negedge clk);
    if (sel == 1) check({name, "_err_pulse_end"}, {err1, busy1}, 0);
    else          check({name, "_err_pulse_end"}, {err4, busy4}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    log2n_cfg = '0; mode = 1'b0; out_ready = 1'b1;

    tbl = '{mk(0,1,0), mk(2,3,0), mk(4,5,0), mk(6,7,0),
            mk(0,2,0), mk(1,3,8), mk(4,6,0), mk(5,7,8),
            mk(0,4,0), mk(1,5,4), mk(2,6,8), mk(3,7,12),
            mk(0,4,0), mk(1,5,4), mk(2,6,8), mk(3,7,12),
            mk(0,2,0), mk(1,3,8), mk(4,6,0), mk(5,7,8),
            mk(0,1,0), mk(2,3,0), mk(4,5,0), mk(6,7,0),
            mk(0,1,0), mk(2,3,0), mk(0,2,0), mk(1,3,8),
            mk(0,1,0),
            mk(0,2,0), mk(1,3,8), mk(0,1,0), mk(2,3,0)};
    runs[0] = '{3, 1'b0, 0,  "dit8"};
    runs[1] = '{3, 1'b1, 12, "dif8"};
    runs[2] = '{2, 1'b0, 24, "dit4"};
    runs[3] = '{1, 1'b0, 28, "n2"};
    runs[4] = '{2, 1'b1, 29, "dif4"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {ov1, a1, b1, k1, st1, last1, ds1, df1, busy1, err1}, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back transforms: each start lands in the cycle done_fft is seen.
    for (int r = 0; r < 5; r++) begin
      push_run(r, runs[r].l * (1 << (runs[r].l - 1)));
      do_start(1, runs[r].l, runs[r].md);
      wait_done(1, 0, runs[r].l * (1 << (runs[r].l - 1)) + 1, runs[r].l, runs[r].name);
    end

    // Stall on stage 1 beat 1 for three cycles.
    push_run(0, 12);
    do_start(1, 3, 1'b0);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_beat", c), {ov1, a1, b1, k1, st1, last1},
            {1'b1, 5'd1, 5'd3, 4'd8, 3'd1, 1'b0});
      check($sformatf("stall%0d_pulses", c), {ds1, df1}, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(1, 8, 16, 2, "stall");

    // Asynchronous reset in the middle of stage 1.
    @(posedge clk);
    #1;
    push_run(0, 5);
    do_start(1, 3, 1'b0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs", {ov1, a1, b1, k1, st1, last1, ds1, df1, busy1}, 0);
    check("midreset_queue", exp_q.size(), 0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    push_run(2, 4);
    do_start(1, 2, 1'b0);
    wait_done(1, 0, 5, 2, "after_reset");

    // Two lanes, N=16, DIT.
    do_start(2, 4, 1'b0);
    wait_done(2, 0, 17, 4, "lanes2");
    check("lanes2_beats", nb2, 16);
    check("lanes2_b0_a", cap_a2[0], {5'd2, 5'd0});
    check("lanes2_b0_b", cap_b2[0], {5'd3, 5'd1});
    check("lanes2_b0_k", cap_k2[0], {4'd0, 4'd0});
    check("lanes2_b13_a", cap_a2[13], {5'd3, 5'd2});
    check("lanes2_b13_b", cap_b2[13], {5'd11, 5'd10});
    check("lanes2_b13_k", cap_k2[13], {4'd6, 4'd4});

    // Config errors, then the smallest legal N for LANES=4.
    cfg_err_check(4, 2, "lanes4_l2");
    cfg_err_check(1, 0, "l0");
    cfg_err_check(1, 6, "l6");
    do_start(4, 3, 1'b0);
    wait_done(4, 0, 4, 3, "lanes4_l3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
